// File: rtl/bcd_result_decoder_pkg.sv
// Shared types for the signed BCD result decoder: FSM states, digit type and decode modes.
package bcd_pkg;

    typedef enum logic {S_LOAD, S_EMIT} state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    typedef enum logic [1:0] {DEC_PASS, DEC_INC, DEC_RECOMP} dec_e;

endpackage

// File: rtl/bcd_result_decoder_if.sv
// Digit-serial input and output handshake bundle of the BCD result decoder.
interface bcd_result_decoder_if;
    import bcd_pkg::*;

    logic       in_valid;
    logic       in_ready;
    bcd_digit_t in_digit;
    logic       in_cout;
    logic       in_mixed;
    logic       in_sign;
    logic       out_valid;
    logic       out_ready;
    bcd_digit_t out_digit;
    logic       out_last;
    logic       out_sign;
    logic       out_ovf;

    modport master (
        output in_valid, in_digit, in_cout, in_mixed, in_sign, out_ready,
        input  in_ready, out_valid, out_digit, out_last, out_sign, out_ovf
    );

    modport slave (
        input  in_valid, in_digit, in_cout, in_mixed, in_sign, out_ready,
        output in_ready, out_valid, out_digit, out_last, out_sign, out_ovf
    );

endinterface

// File: rtl/bcd_result_decoder_digit_fix.sv
// Per-digit correction on the emit path: pass, +carry with decimal wrap, or nines complement.
module bcd_digit_fix
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  logic       carry_i,
    input  dec_e       mode_i,
    output bcd_digit_t digit_o,
    output logic       carry_o
);

    logic [4:0] sum;

    always_comb begin
        sum     = {1'b0, digit_i} + {4'b0000, carry_i};
        digit_o = digit_i;
        carry_o = 1'b0;
        case (mode_i)
            DEC_INC: begin
                // Any sum past 9 wraps to 0 and carries, which also keeps bad input digits bounded
                if (sum > 5'd9) begin
                    digit_o = BCD_ZERO;
                    carry_o = 1'b1;
                end else begin
                    digit_o = sum[3:0];
                end
            end
            DEC_RECOMP: digit_o = BCD_NINE - digit_i;
            default:    digit_o = digit_i;
        endcase
    end

endmodule

// File: rtl/bcd_result_decoder.sv
// Buffers one NDIG-digit nines-complement sum, then emits it as sign-magnitude BCD, LSD first.
// Optional build macro BCD_RD_NEGZERO_CLR_EN: a zero magnitude forces out_sign to 0.
module bcd_result_decoder
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    bcd_result_decoder_if.slave bus
);

    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    bcd_digit_t    buf_q [NDIG];
    bcd_digit_t    buf_d [NDIG];
    dec_e          dec_q, dec_d;
    logic          sign_q, sign_d;
    logic          ovf_q, ovf_d;
    logic          carry_q, carry_d;
`ifdef BCD_RD_NEGZERO_CLR_EN
    logic          all9_q, all9_d;
    logic          all0_q, all0_d;
    logic          all9_now, all0_now;
`endif

    logic       emit;
    logic       cnt_last;
    bcd_digit_t fix_digit;
    logic       fix_carry;

    assign emit     = (state_q == S_EMIT);
    assign cnt_last = (cnt_q == CNT_LAST);

    bcd_digit_fix u_fix (
        .digit_i (buf_q[cnt_q]),
        .carry_i (carry_q),
        .mode_i  (dec_q),
        .digit_o (fix_digit),
        .carry_o (fix_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        dec_d   = dec_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        carry_d = carry_q;
`ifdef BCD_RD_NEGZERO_CLR_EN
        all9_now = (bus.in_digit == BCD_NINE) && ((cnt_q == '0) || all9_q);
        all0_now = (bus.in_digit == BCD_ZERO) && ((cnt_q == '0) || all0_q);
        all9_d   = all9_q;
        all0_d   = all0_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (bus.in_valid) begin
                    buf_d[cnt_q] = bus.in_digit;
`ifdef BCD_RD_NEGZERO_CLR_EN
                    all9_d = all9_now;
                    all0_d = all0_now;
`endif
                    if (cnt_last) begin
                        state_d = S_EMIT;
                        cnt_d   = '0;
                        carry_d = 1'b1;
                        if (!bus.in_mixed) begin
                            dec_d  = DEC_PASS;
                            sign_d = bus.in_sign;
                            ovf_d  = bus.in_cout;
                        end else if (bus.in_cout) begin
                            dec_d  = DEC_INC;
                            sign_d = 1'b0;
                            ovf_d  = 1'b0;
                        end else begin
                            dec_d  = DEC_RECOMP;
                            sign_d = 1'b1;
                            ovf_d  = 1'b0;
                        end
`ifdef BCD_RD_NEGZERO_CLR_EN
                        if (!bus.in_cout && ((bus.in_mixed && all9_now) ||
                                             (!bus.in_mixed && all0_now)))
                            sign_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    carry_d = fix_carry;
                    if (cnt_last) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            for (int i = 0; i < NDIG; i++) buf_q[i] <= BCD_ZERO;
            dec_q   <= DEC_PASS;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
`ifdef BCD_RD_NEGZERO_CLR_EN
            all9_q  <= 1'b0;
            all0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            dec_q   <= dec_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
`ifdef BCD_RD_NEGZERO_CLR_EN
            all9_q  <= all9_d;
            all0_q  <= all0_d;
`endif
        end
    end

    // Outputs are forced to zero outside EMIT so idle and reset values are clean
    assign bus.in_ready  = !emit;
    assign bus.out_valid = emit;
    assign bus.out_digit = emit ? fix_digit : BCD_ZERO;
    assign bus.out_last  = emit && cnt_last;
    assign bus.out_sign  = emit && sign_q;
    assign bus.out_ovf   = emit && ovf_q;

endmodule

// File: tb/tb_bcd_result_decoder.sv
// Scoreboard bench for bcd_result_decoder: word model in decimal arithmetic, random output stalls.
module tb_bcd_result_decoder;
    localparam int NDIG = 4;

    typedef struct packed {
        logic [3:0] digit;
        logic       last;
        logic       sign;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t obs[$];

    bcd_result_decoder_if bus ();

    bcd_result_decoder #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_expected(input logic [15:0] v, input logic cout,
                                          input logic mixed, input logic sign);
        int val = 0;
        int mag;
        logic s, o;
        for (int i = NDIG - 1; i >= 0; i--) val = val * 10 + int'(v[4*i +: 4]);
        if (!mixed) begin
            mag = val; s = sign; o = cout;
        end else if (cout) begin
            mag = (val + 1) % 10000; s = 1'b0; o = 1'b0;
        end else begin
            mag = 9999 - val; s = 1'b1; o = 1'b0;
        end
`ifdef BCD_RD_NEGZERO_CLR_EN
        if (!cout && ((mixed && v == 16'h9999) || (!mixed && v == 16'h0000))) s = 1'b0;
`endif
        for (int i = 0; i < NDIG; i++) begin
            sb.push_back('{digit: 4'(mag % 10), last: (i == NDIG - 1), sign: s, ovf: o});
            mag = mag / 10;
        end
    endfunction

    task automatic send_word(input logic [15:0] v, input logic cout, input logic mixed,
                             input logic sign);
        int guard;
        push_expected(v, cout, mixed, sign);
        for (int i = 0; i < NDIG; i++) begin
            bus.in_valid = 1'b1;
            bus.in_digit = v[4*i +: 4];
            // Side-band fields on non-final digits carry junk that must be ignored
            bus.in_cout  = (i == NDIG - 1) ? cout  : ~cout;
            bus.in_mixed = (i == NDIG - 1) ? mixed : ~mixed;
            bus.in_sign  = (i == NDIG - 1) ? sign  : ~sign;
            guard = 0;
            forever begin
                @(negedge clk);
                if (bus.in_ready || guard > 50) break;
                guard++;
            end
            if (guard > 50) begin
                n_vec++; n_err++;
                $display("FAIL send_timeout: in_ready stuck at %b, required 1", bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int stall_pct, input int take);
        int   n = 0;
        int   guard = 0;
        bit   stalled = 0;
        exp_t prev, cur;
        bus.out_ready = ($urandom_range(99) >= stall_pct);
        while (n < take && guard < 300) begin
            @(negedge clk);
            guard++;
            cur = '{digit: bus.out_digit, last: bus.out_last, sign: bus.out_sign, ovf: bus.out_ovf};
            if (stalled) begin
                n_vec++;
                if (!bus.out_valid || cur !== prev) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%b fields=%h, required valid=1 fields=%h",
                             bus.out_valid, cur, prev);
                end
            end
            stalled = 0;
            if (bus.out_valid) begin
                n_vec++;
                if (bus.in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL in_ready_emit: got %b, required 0", bus.in_ready);
                end
                if (bus.out_ready) begin
                    obs.push_back(cur);
                    n++;
                end else begin
                    stalled = 1;
                    prev = cur;
                end
            end
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(99) >= stall_pct);
        end
        if (n < take) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: got %0d digits, required %0d", n, take);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_vec++;
        if ({bus.in_ready, bus.out_valid, bus.out_digit, bus.out_last, bus.out_sign, bus.out_ovf}
            !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b vld=%b dig=%0d last=%b sign=%b ovf=%b, required 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_digit, bus.out_last, bus.out_sign, bus.out_ovf);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_pass();
        exp_t e, o;
        send_word(16'h0579, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL latency: out_valid=%b in_ready=%b, required 1 0", bus.out_valid, bus.in_ready);
        end
        drain(0, NDIG);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs.size() == 0) begin n_err++; $display("FAIL pass_missing: no digit, required %h", e); end
            else begin
                o = obs.pop_front();
                if (o !== e) begin n_err++; $display("FAIL pass_digit: got %h, required %h", o, e); end
            end
        end
    endtask

    task automatic test_inc();
        exp_t e, o;
        send_word(16'h0376, 1'b1, 1'b1, 1'b1);
        drain(0, NDIG);
        send_word(16'h0999, 1'b1, 1'b1, 1'b0);
        drain(20, NDIG);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs.size() == 0) begin n_err++; $display("FAIL inc_missing: no digit, required %h", e); end
            else begin
                o = obs.pop_front();
                if (o !== e) begin n_err++; $display("FAIL inc_digit: got %h, required %h", o, e); end
            end
        end
    endtask

    task automatic test_recomp();
        exp_t e, o;
        send_word(16'h9622, 1'b0, 1'b1, 1'b0);
        drain(0, NDIG);
        send_word(16'h9999, 1'b0, 1'b1, 1'b0);
        drain(0, NDIG);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs.size() == 0) begin n_err++; $display("FAIL recomp_missing: no digit, required %h", e); end
            else begin
                o = obs.pop_front();
                if (o !== e) begin n_err++; $display("FAIL recomp_digit: got %h, required %h", o, e); end
            end
        end
    endtask

    task automatic test_ovf();
        exp_t e, o;
        send_word(16'h1000, 1'b1, 1'b0, 1'b0);
        drain(0, NDIG);
        send_word(16'h0000, 1'b0, 1'b0, 1'b1);
        drain(0, NDIG);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs.size() == 0) begin n_err++; $display("FAIL ovf_missing: no digit, required %h", e); end
            else begin
                o = obs.pop_front();
                if (o !== e) begin n_err++; $display("FAIL ovf_digit: got %h, required %h", o, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        logic [15:0] v;
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(9));
            send_word(v, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            drain(40, NDIG);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs.size() == 0) begin n_err++; $display("FAIL b2b_missing: no digit, required %h", e); end
            else begin
                o = obs.pop_front();
                if (o !== e) begin n_err++; $display("FAIL b2b_digit: got %h, required %h", o, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        send_word(16'h0376, 1'b1, 1'b1, 1'b0);
        drain(30, 2);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        sb.delete();
        obs.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(16'h9622, 1'b0, 1'b1, 1'b1);
        drain(30, NDIG);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs.size() == 0) begin n_err++; $display("FAIL rmid_missing: no digit, required %h", e); end
            else begin
                o = obs.pop_front();
                if (o !== e) begin n_err++; $display("FAIL rmid_digit: got %h, required %h", o, e); end
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_digit  = 4'd0;
        bus.in_cout   = 1'b0;
        bus.in_mixed  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_pass();
        test_inc();
        test_recomp();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
